// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the AND-gate exercise block:
// input-combination indices and the coverage-vector width.
package and_gate_pkg;

   localparam int unsigned SEEN_W = 4;

   localparam logic [1:0] COMBO_00 = 2'd0;
   localparam logic [1:0] COMBO_01 = 2'd1;
   localparam logic [1:0] COMBO_10 = 2'd2;
   localparam logic [1:0] COMBO_11 = 2'd3;

   // Maps a {a, b} combination to the one-hot coverage bit it sets.
   function automatic logic [SEEN_W-1:0] combo_onehot(input logic [1:0] idx);
      logic [SEEN_W-1:0] hit;
      // NOTE: give the result a default before the case so no path leaves it unassigned (no latch).
      hit = '0;
      case (idx)
         COMBO_00: hit = 4'b0001;
         COMBO_01: hit = 4'b0010;
         COMBO_10: hit = 4'b0100;
         COMBO_11: hit = 4'b1000;
         default:  hit = '0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/and_gate_top_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/and_gate_top.sv
// Bit-wise AND with a registered copy plus observation logic: lane-0
// input-combination coverage and a saturating count of y_q changes.
module and_gate_top
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  y,
   output logic [WIDTH-1:0]  y_q,
   input  logic              clr,
   output logic [SEEN_W-1:0] seen,
   output logic [CNT_W-1:0]  toggle_cnt
);

   logic toggle;

   always_comb begin
      y = a & b;
   end

   // The next y_q equals y, so a difference here is a change on this edge.
   assign toggle = (y != y_q);

   // y_q ignores clr; only the observation state is cleared by it.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q  <= '0;
         seen <= '0;
      end else begin
         y_q <= y;
         if (clr) begin
            seen <= '0;
         end else begin
            seen <= seen | combo_onehot({a[0], b[0]});
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_toggle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (toggle),
      .count (toggle_cnt)
   );

endmodule

// File: tb/tb_and_gate_top.sv
// Directed bench for and_gate_top: scoreboard of expected results checked
// one clock after each stimulus step, plus narrow-counter and wide-lane instances.
module tb_and_gate_top;

   typedef struct {
      string      tag;
      logic       y;
      logic       y_q;
      logic [3:0] seen;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   sat_sb[$];

   int total  = 0;
   int passed = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [0:0] a, b, y, y_q;
   logic [3:0] seen;
   logic [7:0] toggle_cnt;

   logic [0:0] sat_a, sat_b, sat_y, sat_y_q;
   logic [3:0] sat_seen;
   logic [1:0] sat_cnt;

   logic [3:0] wide_a, wide_b, wide_y, wide_y_q;
   logic [3:0] wide_seen;
   logic [7:0] wide_cnt;

   always #5 clk = ~clk;

   and_gate_top #(.WIDTH(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .y(y), .y_q(y_q),
      .clr(clr), .seen(seen), .toggle_cnt(toggle_cnt)
   );

   and_gate_top #(.WIDTH(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .a(sat_a), .b(sat_b), .y(sat_y), .y_q(sat_y_q),
      .clr(clr), .seen(sat_seen), .toggle_cnt(sat_cnt)
   );

   and_gate_top #(.WIDTH(4), .CNT_W(8)) u_wide (
      .clk(clk), .rst(rst), .a(wide_a), .b(wide_b), .y(wide_y), .y_q(wide_y_q),
      .clr(clr), .seen(wide_seen), .toggle_cnt(wide_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Drive one step at posedge+1, then compare one period later (posedge+1 again).
   task automatic step(input logic sa, input logic sb_in, input logic srst, input logic sclr,
                       input string tag, input logic ey, input logic eyq,
                       input logic [3:0] es, input logic [7:0] ec);
      exp_t e;
      a   = sa;
      b   = sb_in;
      rst = srst;
      clr = sclr;
      sb.push_back('{tag, ey, eyq, es, ec});
      #10;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_y"},    {31'd0, y},         {31'd0, e.y});
         check({e.tag, "_y_q"},  {31'd0, y_q},       {31'd0, e.y_q});
         check({e.tag, "_seen"}, {28'd0, seen},      {28'd0, e.seen});
         check({e.tag, "_cnt"},  {24'd0, toggle_cnt}, {24'd0, e.cnt});
      end
   endtask

   initial begin
      rst    = 1'b1;
      clr    = 1'b0;
      a      = 1'b0;
      b      = 1'b0;
      sat_a  = 1'b0;
      sat_b  = 1'b1;
      wide_a = 4'b0000;
      wide_b = 4'b0000;
      @(posedge clk);
      #1;

      // Combinational truth table while reset holds the state at zero.
      step(1'b1, 1'b1, 1'b1, 1'b0, "comb_11", 1'b1, 1'b0, 4'b0000, 8'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, "comb_01", 1'b0, 1'b0, 4'b0000, 8'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, "comb_00", 1'b0, 1'b0, 4'b0000, 8'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0, "comb_10", 1'b0, 1'b0, 4'b0000, 8'd0);

      // Clocked sequence: y_q lags, coverage fills up, two toggles.
      step(1'b1, 1'b1, 1'b0, 1'b0, "seq_11", 1'b1, 1'b1, 4'b1000, 8'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, "seq_01", 1'b0, 1'b0, 4'b1010, 8'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0, "seq_00", 1'b0, 1'b0, 4'b1011, 8'd2);
      step(1'b1, 1'b0, 1'b0, 1'b0, "seq_10", 1'b0, 1'b0, 4'b1111, 8'd2);

      // Reset held with a = b = 1, then released.
      step(1'b1, 1'b1, 1'b1, 1'b0, "rst_hold0", 1'b1, 1'b0, 4'b0000, 8'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, "rst_hold1", 1'b1, 1'b0, 4'b0000, 8'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, "rst_hold2", 1'b1, 1'b0, 4'b0000, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, "rst_rel",   1'b1, 1'b1, 4'b1000, 8'd1);

      // rst beats clr; clr alone clears observation state but y_q still updates.
      step(1'b1, 1'b1, 1'b1, 1'b1, "rst_clr",   1'b1, 1'b0, 4'b0000, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b1, "clr_only",  1'b1, 1'b1, 4'b0000, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, "post_clr",  1'b1, 1'b1, 4'b1000, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, "post_fall", 1'b0, 1'b0, 4'b1001, 8'd1);

      // Fresh reset for the wide and narrow-counter instances.
      rst = 1'b1;
      #10;
      rst    = 1'b0;
      wide_a = 4'b1100;
      wide_b = 4'b1010;
      #1;
      check("wide_y_a", {28'd0, wide_y}, 32'h8);
      check("wide_y_q_pre", {28'd0, wide_y_q}, 32'h0);
      #9;
      check("wide_y_q_a", {28'd0, wide_y_q}, 32'h8);
      wide_a = 4'b1111;
      wide_b = 4'b0110;
      #1;
      check("wide_y_b", {28'd0, wide_y}, 32'h6);
      #9;
      check("wide_y_q_b", {28'd0, wide_y_q}, 32'h6);

      // Alternating a with b = 1: a 2-bit counter saturates at 3.
      for (int i = 0; i < 6; i++) begin
         sat_a = (i % 2 == 0) ? 1'b1 : 1'b0;
         sat_sb.push_back((i + 1 > 3) ? 3 : i + 1);
         #10;
         if (sat_sb.size() != 0) begin
            check($sformatf("sat_cnt_%0d", i), {30'd0, sat_cnt}, sat_sb.pop_front());
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
